// File: rtl/sbox_lut_loader.sv
// Loads a 32-entry, 5-bit S-box image into a LUT responder over a valid/ready register bus.
// Define SBOX_LUT_LOADER_VERIFY_EN to add a read-back verify pass after the write pass.
package sbox_lut_loader_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module sbox_lut_loader
  import sbox_lut_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [159:0] table_i,
  output reg_req_t     reg_req_o,
  input  reg_rsp_t     reg_rsp_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [4:0]   err_idx_o
);

`ifdef SBOX_LUT_LOADER_VERIFY_EN
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
`endif

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t       r_state;
  reg_req_t     r_req;
  logic [159:0] r_table;
  logic [4:0]   r_idx;
  logic [7:0]   r_wait;
  logic         r_busy;
  logic         r_done;
  logic         r_err;
  logic [4:0]   r_err_idx;

  logic         w_hs;
  logic         w_timeout;
  logic         w_fail;
  logic         w_last;
  logic [4:0]   w_idx_nxt;
  logic [4:0]   w_entry_nxt;
  logic [31:0]  w_addr_nxt;
  logic         w_unused;
`ifdef SBOX_LUT_LOADER_VERIFY_EN
  logic [4:0]   w_entry_cur;
`endif

  function automatic logic [4:0] f_entry(input logic [159:0] tbl, input logic [4:0] idx);
    logic [7:0] lo;
    lo = 8'(idx) * 8'd5;
    return tbl[lo +: 5];
  endfunction

  always_comb begin
    w_hs        = r_req.valid & reg_rsp_i.ready;
    w_timeout   = r_req.valid & ~reg_rsp_i.ready & (r_wait == WAIT_LAST);
    w_last      = (r_idx == 5'd31);
    w_idx_nxt   = r_idx + 5'd1;
    w_entry_nxt = f_entry(r_table, w_idx_nxt);
    w_addr_nxt  = BASE_ADDR + {25'b0, w_idx_nxt, 2'b00};
`ifdef SBOX_LUT_LOADER_VERIFY_EN
    w_entry_cur = f_entry(r_table, r_idx);
    w_fail      = w_hs & (reg_rsp_i.error |
                          (~r_req.write & (reg_rsp_i.rdata[4:0] != w_entry_cur)));
    w_unused    = ^reg_rsp_i.rdata[31:5];
`else
    w_fail      = w_hs & reg_rsp_i.error;
    w_unused    = ^reg_rsp_i.rdata;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_req     <= '0;
      r_table   <= '0;
      r_idx     <= '0;
      r_wait    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_err_idx <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_state   <= WRITE;
            r_table   <= table_i;
            r_idx     <= '0;
            r_wait    <= '0;
            r_busy    <= 1'b1;
            r_err     <= 1'b0;
            r_err_idx <= '0;
            r_req     <= '{addr: BASE_ADDR, write: 1'b1, wdata: {27'b0, table_i[4:0]},
                           wstrb: 4'b0001, valid: 1'b1};
          end
        end
        DONE: r_state <= IDLE;
        default: begin
          // Shared by the write and read passes; r_req.write tells them apart.
          if (w_fail || w_timeout) begin
            r_err     <= 1'b1;
            r_err_idx <= r_idx;
            r_req     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end else if (w_hs) begin
            r_wait <= '0;
            if (!w_last) begin
              r_idx       <= w_idx_nxt;
              r_req.addr  <= w_addr_nxt;
              r_req.wdata <= r_req.write ? {27'b0, w_entry_nxt} : '0;
            end
`ifdef SBOX_LUT_LOADER_VERIFY_EN
            else if (r_state == WRITE) begin
              r_idx   <= '0;
              r_state <= READ;
              r_req   <= '{addr: BASE_ADDR, write: 1'b0, wdata: '0, wstrb: '0, valid: 1'b1};
            end
`endif
            else begin
              r_req   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end else if (r_req.valid) begin
            r_wait <= r_wait + 8'd1;
          end
        end
      endcase
    end
  end

  assign reg_req_o = r_req;
  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign err_o     = r_err;
  assign err_idx_o = r_err_idx;

endmodule

// File: doc/sbox_lut_loader.md
SBOX_LUT_LOADER -- requirements
Module: sbox_lut_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of S-box LUT entry 0.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum cycles a request may wait for ready (range 1..255).
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start_i  input  1  one-cycle load request.
REQ-006 SHALL have port table_i  input  160  S-box image; entry i at bits [5i+4:5i].
REQ-007 SHALL have port reg_req_o  output  reg_req_t  register-interface request to the S-box LUT responder (addr, write, wdata, wstrb, valid).
REQ-008 SHALL have port reg_rsp_i  input  reg_rsp_t  responder reply (rdata, error, ready).
REQ-009 SHALL have port busy_o  output  1  high from the cycle after an accepted start until the done pulse.
REQ-010 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-011 SHALL have port err_o  output  1  sticky failure flag.
REQ-012 SHALL have port err_idx_o  output  5  entry index of first failure.

Function
REQ-013 SHALL implement FSM states IDLE, WRITE, READ, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-014 SHALL accept start_i only in IDLE; start_i in any other state is ignored.
REQ-015 SHALL on accepted start capture table_i, clear err_o and err_idx_o, reset index to 0, enter WRITE.
REQ-016 SHALL in WRITE drive valid=1, write=1, addr=BASE_ADDR+4*idx, wdata={27'b0, entry[idx]}, wstrb=4'b0001.
REQ-017 SHALL hold addr, write, wdata, wstrb stable while valid=1 and ready=0.
REQ-018 SHALL treat a cycle with valid=1 and ready=1 as a completed transaction; next request presented the following cycle with no bubble.
REQ-019 SHALL after write of idx 31 enter READ (verify enabled) or DONE (verify disabled); index wraps to 0 on entering READ.
REQ-020 SHALL in READ drive valid=1, write=0, addr=BASE_ADDR+4*idx, wdata=0, wstrb=0, and compare rdata[4:0] with entry[idx] at the handshake.
REQ-021 SHALL on handshake with error=1, or read mismatch, set err_o=1, err_idx_o=idx, drop valid next cycle, enter DONE.
REQ-022 SHALL count consecutive cycles with valid=1 and ready=0; on reaching TIMEOUT set err_o=1, err_idx_o=idx, drop valid, enter DONE.
REQ-023 SHALL reset the wait counter at every handshake.
REQ-024 SHALL after read of idx 31 without failure enter DONE with err_o=0.
REQ-025 SHALL pulse done_o in DONE on both success and failure; err_o qualifies the outcome and holds until next accepted start or reset.
REQ-026 SHALL complete a full load with ready always high in exactly 1+32 cycles (no verify) or 1+64 cycles (verify) from start to done_o.

Reset
REQ-027 SHALL on rst_i=1 at a clock edge enter IDLE; reg_req_o all fields 0, busy_o=0, done_o=0, err_o=0, err_idx_o=0, counters 0.
REQ-028 SHALL honour rst_i mid-transaction: valid drops at that edge, no done_o pulse, captured table discarded.

Configuration
REQ-029 SHALL compile READ-back verify in when SBOX_LUT_LOADER_VERIFY_EN is defined (WRITE->READ->DONE).
REQ-030 SHALL without SBOX_LUT_LOADER_VERIFY_EN omit READ state and compare logic; WRITE->DONE, write=1 on every request.

Verification
REQ-031 SHALL cover: Ascon S-box table (entry0=5'h04, entry31=5'h17), ready tied high, verify on -> 32 writes then 32 reads at 0x00..0x7C, done_o at cycle 65, err_o=0.
REQ-032 SHALL cover: responder ready low 3 cycles on idx 7 write -> addr 0x1C, wdata 5'h02 held stable 4 cycles, load completes err_o=0.
REQ-033 SHALL cover: error=1 on write handshake idx 12 -> err_o=1, err_idx_o=12, no request for idx 13, done_o pulses.
REQ-034 SHALL cover: readback of idx 20 returns 5'h01 instead of 5'h00 -> err_o=1, err_idx_o=20, done_o pulses.
REQ-035 SHALL cover: ready held low, TIMEOUT=4 -> valid drops after 4 waiting cycles, err_o=1, err_idx_o=0.
REQ-036 SHALL cover: rst_i asserted at idx 10 and start_i pulsed while busy -> valid=0 next cycle, no done_o, second start ignored.
